// File: rtl/nibble_serial_comparator_if.sv
// Operand/result bundle for the nibble-serial magnitude comparator.
interface nibble_serial_comparator_if #(
  parameter int NIB = 8
);
  logic              start;
  logic [4*NIB-1:0]  a;
  logic [4*NIB-1:0]  b;
  logic              busy;
  logic              done;
  logic              agtb;
  logic              altb;
  logic              aeqb;

  modport master (
    output start, a, b,
    input  busy, done, agtb, altb, aeqb
  );

  modport slave (
    input  start, a, b,
    output busy, done, agtb, altb, aeqb
  );
endinterface

// File: rtl/nibble_serial_comparator.sv
// Wide unsigned magnitude compare, one nibble per clock (MSB first) through a
// single 4-bit cascadable comparator; first non-equal nibble ends the compare.
module comp4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       agtb_in,
  input  logic       altb_in,
  input  logic       aeqb_in,
  output logic       agtb,
  output logic       altb,
  output logic       aeqb
);
  always_comb begin
    agtb = 1'b0;
    altb = 1'b0;
    aeqb = 1'b0;
    if (a > b) begin
      agtb = 1'b1;
    end else if (a < b) begin
      altb = 1'b1;
    end else begin
      agtb = agtb_in;
      altb = altb_in;
      aeqb = aeqb_in;
    end
  end
endmodule

module nibble_serial_comparator #(
  parameter int NIB = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  nibble_serial_comparator_if.slave  bus
);
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CMP  = 2'b01;

  logic [1:0]       state;
  logic [4*NIB-1:0] ra;
  logic [4*NIB-1:0] rb;
  logic [IW-1:0]    idx;
  logic [3:0]       na;
  logic [3:0]       nb;
  logic             c_gt;
  logic             c_lt;
  logic             c_eq;
  logic             done_q;
  logic             agtb_q;
  logic             altb_q;
  logic             aeqb_q;

  assign na = ra[{idx, 2'b00} +: 4];
  assign nb = rb[{idx, 2'b00} +: 4];

  comp4bit u_comp (
    .a       (na),
    .b       (nb),
    .agtb_in (1'b0),
    .altb_in (1'b0),
    .aeqb_in (1'b1),
    .agtb    (c_gt),
    .altb    (c_lt),
    .aeqb    (c_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      idx    <= '0;
      done_q <= 1'b0;
      agtb_q <= 1'b0;
      altb_q <= 1'b0;
      aeqb_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ra    <= bus.a;
            rb    <= bus.b;
            idx   <= IW'(NIB - 1);
            state <= CMP;
          end
        end
        CMP: begin
          // Results only move together with done, so they never glitch mid-compare.
          if (c_gt || c_lt || (idx == '0)) begin
            agtb_q <= c_gt;
            altb_q <= c_lt;
            aeqb_q <= c_eq;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == CMP);
  assign bus.done = done_q;
  assign bus.agtb = agtb_q;
  assign bus.altb = altb_q;
  assign bus.aeqb = aeqb_q;
endmodule

// File: tb/tb_nibble_serial_comparator.sv
// Bench for nibble_serial_comparator: arithmetic reference model checked every
// cycle, plus literal latency/result expectations for the directed cases.
module tb_nibble_serial_comparator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_comparator_if #(.NIB(8)) bus8 ();
  nibble_serial_comparator_if #(.NIB(1)) bus1 ();

  nibble_serial_comparator #(.NIB(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  nibble_serial_comparator #(.NIB(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Nibbles examined = NIB minus the nibble index holding the top differing bit.
  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    d = x ^ y;
    if (d == 0) return 8;
    for (int i = 31; i >= 0; i--)
      if (d[i]) return 8 - i / 4;
    return 8;
  endfunction

  function automatic logic [2:0] exp_res(input logic [31:0] x, input logic [31:0] y);
    if (x > y) return 3'b100;
    if (x < y) return 3'b010;
    return 3'b001;
  endfunction

  bit         m_busy;
  bit         m_done;
  logic [2:0] m_res;
  logic [2:0] m_pend;
  int         m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_done = 0;
      m_res  = 3'b000;
      m_cnt  = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0;
          m_done = 1;
          m_res  = m_pend;
        end
      end else if (bus8.start) begin
        m_busy = 1;
        m_cnt  = exp_lat(bus8.a, bus8.b);
        m_pend = exp_res(bus8.a, bus8.b);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", bus8.busy, m_busy);
      check("done", bus8.done, m_done);
      check("result", {bus8.agtb, bus8.altb, bus8.aeqb}, m_res);
    end
  end

  task automatic run_cmp(input logic [31:0] av, input logic [31:0] bv, input bit tog,
                         input int extra_at, output int n, output logic [2:0] res);
    bus8.a = av;
    bus8.b = bv;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    n = 0;
    while (!bus8.done && n < 20) begin
      if (tog) begin
        bus8.a = $urandom;
        bus8.b = $urandom;
      end
      bus8.start = (n == extra_at);
      @(negedge clk);
      n++;
    end
    bus8.start = 1'b0;
    res = {bus8.agtb, bus8.altb, bus8.aeqb};
  endtask

  task automatic run_cmp1(input logic [3:0] av, input logic [3:0] bv, output int n,
                          output logic [2:0] res);
    bus1.a = av;
    bus1.b = bv;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    check("nib1_busy_e0", bus1.busy, 1'b1);
    n = 0;
    while (!bus1.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("nib1_busy_at_done", bus1.busy, 1'b0);
    res = {bus1.agtb, bus1.altb, bus1.aeqb};
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [2:0] r;
    logic [31:0] av, bv;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;

    #12;
    check("rst_busy", bus8.busy, 1'b0);
    check("rst_done", bus8.done, 1'b0);
    check("rst_result", {bus8.agtb, bus8.altb, bus8.aeqb}, 3'b000);
    check("rst_nib1_result", {bus1.agtb, bus1.altb, bus1.aeqb}, 3'b000);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    run_cmp(32'h1234_5678, 32'h1234_5678, 0, -1, n, r);
    check("equal_latency", n, 8);
    check("equal_result", r, 3'b001);
    // Back-to-back: issued from inside the done cycle.
    run_cmp(32'h9000_0000, 32'h8FFF_FFFF, 0, -1, n, r);
    check("msb_gt_latency", n, 1);
    check("msb_gt_result", r, 3'b100);
    run_cmp(32'h0000_0001, 32'h0000_0002, 1, -1, n, r);
    check("lsb_lt_latency", n, 8);
    check("lsb_lt_result", r, 3'b010);
    run_cmp(32'hAAAA_5555, 32'hAAAA_5555, 0, 2, n, r);
    check("start_while_busy_latency", n, 8);
    check("start_while_busy_result", r, 3'b001);
    run_cmp(32'h00F0_0000, 32'h0010_0000, 0, -1, n, r);
    check("third_nibble_latency", n, 3);
    check("third_nibble_result", r, 3'b100);

    bus8.a = 32'hCAFE_F00D;
    bus8.b = 32'hCAFE_F00D;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", bus8.busy, 1'b0);
    check("abort_done", bus8.done, 1'b0);
    check("abort_result", {bus8.agtb, bus8.altb, bus8.aeqb}, 3'b000);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", {bus8.done, bus8.agtb, bus8.altb, bus8.aeqb}, 4'b0000);
    run_cmp(32'h0000_0000, 32'hFFFF_FFFF, 0, -1, n, r);
    check("post_reset_latency", n, 1);
    check("post_reset_result", r, 3'b010);

    run_cmp1(4'hA, 4'h5, n, r);
    check("nib1_gt_latency", n, 1);
    check("nib1_gt_result", r, 3'b100);
    run_cmp1(4'h7, 4'h7, n, r);
    check("nib1_eq_latency", n, 1);
    check("nib1_eq_result", r, 3'b001);
    run_cmp1(4'h3, 4'hC, n, r);
    check("nib1_lt_result", r, 3'b010);

    for (int i = 0; i < 2000; i++) begin
      av = $urandom;
      case ($urandom_range(0, 2))
        0: bv = $urandom;
        1: bv = av;
        default: bv = av ^ (32'h1 << (4 * $urandom_range(0, 7) + $urandom_range(0, 3)));
      endcase
      run_cmp(av, bv, 0, -1, n, r);
      check("rand_latency", n, exp_lat(av, bv));
      check("rand_result", r, exp_res(av, bv));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nibble_serial_comparator.md
# nibble_serial_comparator

Multi-cycle magnitude comparator for wide unsigned operands (4·NIB bits). It steps through the operands one nibble per clock, MSB nibble first, and feeds each nibble pair through a single `comp4bit` instance. The `comp4bit` cascade inputs are tied to the equal state (`agtb_in=0`, `altb_in=0`, `aeqb_in=1`). The block consumes the `comp4bit` agtb/altb/aeqb outputs and registers the first non-equal decision, or "equal" after the last nibble. It sits directly downstream of `comp4bit`, so wide compares can be made without widening the comparator hardware.

## Interface
Parameters:
- NIB, default 8: number of nibbles per operand. Operand width is 4·NIB. Legal range is 1..16.

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- start  input  1  request a compare. Sampled only in IDLE.
- a  input  4·NIB  operand A, unsigned. Captured on the accepting edge.
- b  input  4·NIB  operand B, unsigned. Captured on the accepting edge.
- busy  output  1  high while a compare is in progress (state CMP).
- done  output  1  one-cycle pulse: result outputs have just been updated.
- agtb  output  1  registered result A>B.
- altb  output  1  registered result A<B.
- aeqb  output  1  registered result A==B.

## Operation
- States: IDLE, CMP. No other encodings are reachable. Any illegal state recovers to IDLE on the next edge.
- IDLE: if start=1 on an edge, latch a→ra and b→rb, set idx=NIB-1, and go to CMP. Otherwise remain in IDLE.
- CMP, each cycle: `comp4bit` compares ra[4·idx+3:4·idx] with rb[4·idx+3:4·idx].
  - If agtb or altb from `comp4bit` is high: register that one-hot result, pulse done, and go to IDLE (early termination).
  - Else, if idx==0: register aeqb=1 (agtb=altb=0), pulse done, and go to IDLE.
  - Else: idx←idx-1 and stay in CMP.
- The result outputs are always one-hot after the first done. They hold their value until the next done, and are never updated mid-compare.
- a and b are ignored after capture. Changing them during CMP has no effect.
- start while busy=1 is ignored; it is not queued.
- idx width is ceil(log2(NIB)), minimum 1. idx never wraps below 0.
- NIB=1: every compare finishes in one CMP cycle.

## Timing
- Reset values: state=IDLE, busy=0, done=0, agtb=0, altb=0, aeqb=0. The all-zero result means "no result yet".
- Reset asserted mid-compare: the compare aborts immediately with no done pulse. Outputs go to reset values.
- Let E0 be the edge that accepts start.
  - busy=1 from E0.
  - If the decision is made on nibble index NIB-k, the result and done=1 appear at edge Ek (k = nibbles examined, 1..NIB), and busy=0 at Ek.
- Latency, start edge to done edge:
  - k cycles for a difference first found in the k-th nibble from the MSB.
  - NIB cycles when the operands are equal.
- done is high for exactly one cycle (Ek to Ek+1).
- During the done cycle the state is IDLE, so a start in that cycle is accepted at Ek+1. The next compare runs back-to-back with no dead cycle.
- busy and done are never both high.

## Test plan
- NIB=8, a=32'h1234_5678, b=32'h1234_5678 → done at E8 with aeqb=1, agtb=altb=0. busy high for exactly 8 cycles.
- a=32'h9000_0000, b=32'h8FFF_FFFF → done at E1 with agtb=1 (early termination on the MSB nibble). busy high for exactly 1 cycle.
- a=32'h0000_0001, b=32'h0000_0002 → done at E8 with altb=1. Toggling a and b randomly during CMP does not change the result.
- Start pulsed at E0 and again at E3 during busy → only one done, at E8. A second start in the done cycle → accepted, and its done arrives 1–8 cycles later, with no lost cycle.
- rst_n driven low at E4 of an equal compare → busy, done and all result bits go to 0 asynchronously. No done follows after release, and the next start behaves normally.
- NIB=1 build: a=4'hA, b=4'h5 → agtb at E1. a=b=4'h7 → aeqb at E1. Random 2000-compare run for NIB=8 against a reference model checks the one-hot result and the latency rule.
